// File: rtl/muldiv_pkg.sv
// Shared types and op-decode helpers for the iterative multiply/divide unit.
package muldiv_pkg;

    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } op_t;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        SIGN,
        DONE
    } state_t;

    function automatic logic is_div(op_t op);
        return op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
    endfunction

    function automatic logic is_rem(op_t op);
        return op inside {OP_REM, OP_REMU};
    endfunction

    function automatic logic is_signed_a(op_t op);
        return op inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
    endfunction

    function automatic logic is_signed_b(op_t op);
        return op inside {OP_MULH, OP_DIV, OP_REM};
    endfunction

endpackage

// File: rtl/muldiv_if.sv
// Request/response handshake bundle between the execute stage and the multiply/divide unit.
interface muldiv_if #(
    parameter int XLEN = 32
);
    import muldiv_pkg::*;

    logic            start_valid;
    logic            start_ready;
    op_t             op;
    logic [XLEN-1:0] rs1;
    logic [XLEN-1:0] rs2;
    logic            result_valid;
    logic            result_ready;
    logic [XLEN-1:0] result;
    logic            busy;

    modport master (
        output start_valid, op, rs1, rs2, result_ready,
        input  start_ready, result_valid, result, busy
    );

    modport slave (
        input  start_valid, op, rs1, rs2, result_ready,
        output start_ready, result_valid, result, busy
    );

endinterface

// File: rtl/muldiv_iter.sv
// Unsigned iteration engine: one shift-add multiply or restoring divide step per cycle.
module muldiv_iter #(
    parameter int XLEN = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic              step,
    input  logic              div_op,
    input  logic [XLEN-1:0]   a_mag,
    input  logic [XLEN-1:0]   b_mag,
    output logic              last,
    output logic [2*XLEN-1:0] product,
    output logic [XLEN-1:0]   quotient,
    output logic [XLEN-1:0]   remainder
);

    localparam int COUNT_W = $clog2(XLEN + 1);

    logic [COUNT_W-1:0] count;
    logic               div_mode;
    // hi is the partial remainder when dividing and the upper accumulator half when multiplying.
    logic [XLEN:0]      hi;
    logic [XLEN-1:0]    lo;
    logic [XLEN-1:0]    opnd;
    logic [XLEN:0]      mul_sum;
    logic [XLEN:0]      shifted;
    logic [XLEN+1:0]    trial;

    // NOTE: every variable assigned in always_comb gets a value on every path, otherwise a latch is inferred.
    always_comb begin
        mul_sum = hi + (lo[0] ? {1'b0, opnd} : '0);
        shifted = {hi[XLEN-1:0], lo[XLEN-1]};
        trial   = {1'b0, shifted} - {2'b00, opnd};
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count    <= '0;
            div_mode <= 1'b0;
            hi       <= '0;
            lo       <= '0;
            opnd     <= '0;
        end else if (load) begin
            count    <= COUNT_W'(XLEN);
            div_mode <= div_op;
            hi       <= '0;
            lo       <= div_op ? a_mag : b_mag;
            opnd     <= div_op ? b_mag : a_mag;
        end else if (step) begin
            count <= count - COUNT_W'(1);
            if (div_mode) begin
                // Negative trial difference means the divisor did not fit: restore.
                if (!trial[XLEN+1]) begin
                    hi <= trial[XLEN:0];
                    lo <= {lo[XLEN-2:0], 1'b1};
                end else begin
                    hi <= shifted;
                    lo <= {lo[XLEN-2:0], 1'b0};
                end
            end else begin
                hi <= {1'b0, mul_sum[XLEN:1]};
                lo <= {mul_sum[0], lo[XLEN-1:1]};
            end
        end
    end

    assign last      = (count == COUNT_W'(1));
    assign product   = {hi[XLEN-1:0], lo};
    assign quotient  = lo;
    assign remainder = hi[XLEN-1:0];

endmodule

// File: rtl/muldiv_unit.sv
// RV32M multiply/divide unit: magnitude iteration with sign fix-up and a divide fast path.
module muldiv_unit #(
    parameter int XLEN = 32
) (
    input  logic    clk,
    input  logic    reset,
    muldiv_if.slave bus
);
    import muldiv_pkg::*;

    localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

    state_t            state;
    state_t            state_next;
    op_t               op_in;
    op_t               op_q;
    logic              neg_q;
    logic              neg_next;
    logic              sign_a;
    logic              sign_b;
    logic              div_zero;
    logic              div_ovf;
    logic              fast;
    logic              accept;
    logic              iter_last;
    logic [XLEN-1:0]   a_mag;
    logic [XLEN-1:0]   b_mag;
    logic [XLEN-1:0]   fast_val;
    logic [XLEN-1:0]   sign_val;
    logic [XLEN-1:0]   result_q;
    logic [XLEN-1:0]   quotient;
    logic [XLEN-1:0]   remainder;
    logic [2*XLEN-1:0] product;
    logic [2*XLEN-1:0] prod_fix;

    assign op_in  = bus.op;
    assign accept = (state == IDLE) && bus.start_valid;

    // Operand magnitudes, result sign and fast-path decision, all taken at the accepting edge.
    always_comb begin
        sign_a   = is_signed_a(op_in) && bus.rs1[XLEN-1];
        sign_b   = is_signed_b(op_in) && bus.rs2[XLEN-1];
        a_mag    = sign_a ? -bus.rs1 : bus.rs1;
        b_mag    = sign_b ? -bus.rs2 : bus.rs2;
        neg_next = is_rem(op_in) ? sign_a : (sign_a ^ sign_b);
        div_zero = is_div(op_in) && (bus.rs2 == '0);
        div_ovf  = (op_in inside {OP_DIV, OP_REM}) && (bus.rs1 == MOST_NEG) && (bus.rs2 == '1);
        fast     = div_zero || div_ovf;
        fast_val = '0;
        if (div_zero) begin
            fast_val = is_rem(op_in) ? bus.rs1 : '1;
        end else if (div_ovf) begin
            fast_val = is_rem(op_in) ? '0 : MOST_NEG;
        end
    end

    muldiv_iter #(
        .XLEN(XLEN)
    ) u_iter (
        .clk       (clk),
        .reset     (reset),
        .load      (accept && !fast),
        .step      (state == CALC),
        .div_op    (is_div(op_in)),
        .a_mag     (a_mag),
        .b_mag     (b_mag),
        .last      (iter_last),
        .product   (product),
        .quotient  (quotient),
        .remainder (remainder)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (bus.start_valid) state_next = fast ? DONE : CALC;
            CALC:    if (iter_last) state_next = SIGN;
            SIGN:    state_next = DONE;
            DONE:    if (bus.result_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Negation wraps modulo 2^XLEN; MULH* take the upper word of the corrected product.
    always_comb begin
        prod_fix = neg_q ? -product : product;
        sign_val = '0;
        case (op_q)
            OP_MUL:                       sign_val = prod_fix[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: sign_val = prod_fix[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU:              sign_val = neg_q ? -quotient : quotient;
            default:                      sign_val = neg_q ? -remainder : remainder;
        endcase
    end

    // NOTE: reset clears the result register too, so an aborted operation leaves no stale value visible.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            op_q     <= OP_MUL;
            neg_q    <= 1'b0;
            result_q <= '0;
        end else begin
            if (accept) begin
                op_q  <= op_in;
                neg_q <= neg_next;
                if (fast) result_q <= fast_val;
            end
            if (state == SIGN) result_q <= sign_val;
        end
    end

    assign bus.start_ready  = (state == IDLE);
    assign bus.busy         = (state != IDLE);
    assign bus.result_valid = (state == DONE);
    assign bus.result       = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: directed RV32M cases, backpressure, reset abort, random ops.
module tb_muldiv_unit;
    import muldiv_pkg::*;

    localparam int XLEN = 32;
    localparam logic [31:0] MIN_INT = 32'h8000_0000;

    typedef struct {
        logic [31:0] exp;
        int          lat;
        int          acc;
        string       name;
    } item_t;

    logic  clk = 1'b0;
    logic  reset;
    int    cyc = 0;
    int    checks = 0;
    int    errors = 0;
    bit    seen = 1'b0;
    bit    rr_auto = 1'b0;
    bit    rr_level = 1'b1;
    bit    rr_rand = 1'b1;
    item_t sb[$];

    muldiv_if #(.XLEN(XLEN)) bus ();

    muldiv_unit #(.XLEN(XLEN)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc     <= cyc + 1;
        rr_rand <= ($urandom_range(0, 3) != 0);
    end

    assign bus.result_ready = rr_auto ? rr_rand : rr_level;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference behaviour from the RV32M definitions using 64-bit integer arithmetic.
    function automatic logic [31:0] model(op_t op, logic [31:0] a, logic [31:0] b);
        longint      sa;
        longint      sb_;
        longint      ua;
        longint      ub;
        logic [63:0] p;
        sa  = $signed(a);
        sb_ = $signed(b);
        ua  = {32'b0, a};
        ub  = {32'b0, b};
        p   = '0;
        case (op)
            OP_MUL:    p = ua * ub;
            OP_MULH:   p = (sa * sb_) >>> 32;
            OP_MULHSU: p = (sa * ub) >>> 32;
            OP_MULHU:  p = (ua * ub) >> 32;
            OP_DIV:    p = (b == 0) ? 64'hFFFF_FFFF : (a == MIN_INT && b == 32'hFFFF_FFFF) ? 64'(MIN_INT) : 64'(sa / sb_);
            OP_DIVU:   p = (b == 0) ? 64'hFFFF_FFFF : 64'(ua / ub);
            OP_REM:    p = (b == 0) ? 64'(a) : (a == MIN_INT && b == 32'hFFFF_FFFF) ? 64'd0 : 64'(sa % sb_);
            default:   p = (b == 0) ? 64'(a) : 64'(ua % ub);
        endcase
        return p[31:0];
    endfunction

    function automatic int latency_of(op_t op, logic [31:0] a, logic [31:0] b);
        bit divide = (op == OP_DIV) || (op == OP_DIVU) || (op == OP_REM) || (op == OP_REMU);
        bit ovf    = ((op == OP_DIV) || (op == OP_REM)) && (a == MIN_INT) && (b == 32'hFFFF_FFFF);
        return (divide && (b == 0 || ovf)) ? 1 : XLEN + 2;
    endfunction

    function automatic logic [31:0] rand_opnd();
        case ($urandom_range(0, 7))
            0:       return 32'h0;
            1:       return 32'hFFFF_FFFF;
            2:       return MIN_INT;
            3:       return 32'h7FFF_FFFF;
            4:       return 32'($urandom_range(1, 15));
            default: return $urandom;
        endcase
    endfunction

    task automatic issue(input op_t op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp, input bit push, input string name);
        int    guard = 0;
        item_t it;
        while (!bus.start_ready && guard < 300) begin
            @(negedge clk);
            guard++;
        end
        if (!bus.start_ready) begin
            checks++;
            errors++;
            $display("FAIL %s_issue_timeout: start_ready=%0b, expected 1", name, bus.start_ready);
            return;
        end
        bus.op          = op;
        bus.rs1         = a;
        bus.rs2         = b;
        bus.start_valid = 1'b1;
        @(posedge clk);
        #1;
        if (push) begin
            it.exp  = exp;
            it.lat  = latency_of(op, a, b);
            it.acc  = cyc;
            it.name = name;
            sb.push_back(it);
        end
        bus.start_valid = 1'b0;
        bus.op          = op_t'($urandom_range(0, 7));
        bus.rs1         = $urandom;
        bus.rs2         = $urandom;
    endtask

    task automatic wait_idle(input string name);
        int guard = 0;
        while (!bus.start_ready && guard < 300) begin
            @(negedge clk);
            guard++;
        end
        check({name, "_idle"}, 32'(bus.start_ready), 32'd1);
    endtask

    // Monitor: latency on first sight of result_valid, value on the accepting handshake.
    always @(negedge clk) begin
        if (!reset) begin
            seen = 1'b0;
        end else if (bus.result_valid) begin
            if (!seen) begin
                seen = 1'b1;
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_result: got 0x%08h, expected no result", bus.result);
                end else begin
                    check({sb[0].name, "_latency"}, 32'(cyc - sb[0].acc + 1), 32'(sb[0].lat));
                end
            end
            if (bus.result_ready) begin
                if (sb.size() != 0) begin
                    check(sb[0].name, bus.result, sb[0].exp);
                    void'(sb.pop_front());
                end
                seen = 1'b0;
            end
        end
    end

    op_t         d_op[10];
    logic [31:0] d_a[10];
    logic [31:0] d_b[10];
    logic [31:0] d_e[10];

    initial begin
        d_op[0] = OP_MULH;   d_a[0] = 32'h8000_0000; d_b[0] = 32'h8000_0000; d_e[0] = 32'h4000_0000;
        d_op[1] = OP_MULHU;  d_a[1] = 32'hFFFF_FFFF; d_b[1] = 32'hFFFF_FFFF; d_e[1] = 32'hFFFF_FFFE;
        d_op[2] = OP_MULHSU; d_a[2] = 32'hFFFF_FFFF; d_b[2] = 32'hFFFF_FFFF; d_e[2] = 32'hFFFF_FFFF;
        d_op[3] = OP_DIV;    d_a[3] = 32'hFFFF_FFF9; d_b[3] = 32'd2;         d_e[3] = 32'hFFFF_FFFD;
        d_op[4] = OP_REM;    d_a[4] = 32'hFFFF_FFF9; d_b[4] = 32'd2;         d_e[4] = 32'hFFFF_FFFF;
        d_op[5] = OP_DIVU;   d_a[5] = 32'd100;       d_b[5] = 32'd7;         d_e[5] = 32'd14;
        d_op[6] = OP_REMU;   d_a[6] = 32'd100;       d_b[6] = 32'd7;         d_e[6] = 32'd2;
        d_op[7] = OP_DIV;    d_a[7] = 32'd5;         d_b[7] = 32'd0;         d_e[7] = 32'hFFFF_FFFF;
        d_op[8] = OP_REMU;   d_a[8] = 32'd5;         d_b[8] = 32'd0;         d_e[8] = 32'd5;
        d_op[9] = OP_DIV;    d_a[9] = 32'h8000_0000; d_b[9] = 32'hFFFF_FFFF; d_e[9] = 32'h8000_0000;

        reset           = 1'b0;
        bus.start_valid = 1'b0;
        bus.op          = OP_MUL;
        bus.rs1         = '0;
        bus.rs2         = '0;

        #12;
        check("reset_result_valid", 32'(bus.result_valid), 32'd0);
        check("reset_busy", 32'(bus.busy), 32'd0);
        check("reset_result", bus.result, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("post_reset_start_ready", 32'(bus.start_ready), 32'd1);

        // MUL 7 * -3 with start_ready held low for the whole operation.
        issue(OP_MUL, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b1, "mul_7_m3");
        for (int i = 0; i < XLEN + 1; i++) begin
            @(negedge clk);
            check("mul_start_ready_low", 32'(bus.start_ready), 32'd0);
        end

        for (int i = 0; i < 10; i++) begin
            issue(d_op[i], d_a[i], d_b[i], d_e[i], 1'b1, $sformatf("dir%0d_%s", i, d_op[i].name()));
        end
        issue(OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1'b1, "rem_ovf");

        // Backpressure: result held in DONE, start pulses ignored, then back-to-back issue.
        wait_idle("bp_pre");
        #1 rr_level = 1'b0;
        issue(OP_DIVU, 32'd100, 32'd7, 32'd14, 1'b1, "bp_divu");
        begin
            int guard = 0;
            while (!bus.result_valid && guard < 100) begin
                @(negedge clk);
                guard++;
            end
        end
        for (int i = 0; i < 5; i++) begin
            check("bp_hold_valid", 32'(bus.result_valid), 32'd1);
            check("bp_hold_result", bus.result, 32'd14);
            check("bp_hold_start_ready", 32'(bus.start_ready), 32'd0);
            bus.start_valid = (i % 2 == 0);
            bus.op          = OP_MUL;
            bus.rs1         = $urandom;
            bus.rs2         = $urandom;
            @(negedge clk);
        end
        bus.start_valid = 1'b0;
        @(posedge clk);
        #1 rr_level = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("bp_back_idle_ready", 32'(bus.start_ready), 32'd1);
        check("bp_back_idle_valid", 32'(bus.result_valid), 32'd0);
        check("bp_result_kept", bus.result, 32'd14);
        issue(OP_MUL, 32'd6, 32'd7, 32'd42, 1'b1, "b2b_mul");

        // Asynchronous reset in the middle of CALC aborts the operation.
        wait_idle("abort_pre");
        issue(OP_MUL, 32'd123, 32'd456, 32'd0, 1'b0, "abort_mul");
        repeat (22) @(posedge clk);
        #2 reset = 1'b0;
        #1;
        check("abort_result_valid", 32'(bus.result_valid), 32'd0);
        check("abort_busy", 32'(bus.busy), 32'd0);
        check("abort_result", bus.result, 32'd0);
        @(negedge clk);
        @(negedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        check("abort_start_ready", 32'(bus.start_ready), 32'd1);
        issue(OP_DIVU, 32'd9, 32'd3, 32'd3, 1'b1, "abort_divu");

        // Random operations against the reference model with random result_ready.
        rr_auto = 1'b1;
        for (int n = 0; n < 250; n++) begin
            op_t         op;
            logic [31:0] a;
            logic [31:0] b;
            op = op_t'($urandom_range(0, 7));
            a  = rand_opnd();
            b  = rand_opnd();
            issue(op, a, b, model(op, a, b), 1'b1, $sformatf("rnd%0d_%s", n, op.name()));
        end
        @(posedge clk);
        #1;
        rr_auto  = 1'b0;
        rr_level = 1'b1;
        begin
            int guard = 0;
            while ((sb.size() != 0 || !bus.start_ready) && guard < 300) begin
                @(negedge clk);
                guard++;
            end
        end
        check("drain_queue_empty", 32'(sb.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
